imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_uart_rx.sv | 81 ++++++++
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared loader definitions: session/receiver state encodings and default bit timing.
package loader_defs;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_FINISH
    } session_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART byte receiver with 2-flop input synchronizer and mid-bit sampling.
module uart_rx
    import loader_defs::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    rx_state_t     r_state, w_next;
    logic [1:0]    r_sync;
    logic          r_rx_prev;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_valid, r_ferr;
    logic          w_rx, w_bit_tick, w_half_tick;

    assign w_rx        = r_sync[1];
    assign w_bit_tick  = (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_half_tick = (r_cnt == CW'(CLKS_PER_BIT / 2 - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE:  if (r_rx_prev && !w_rx) w_next = RX_START;
            RX_START: if (w_half_tick) w_next = w_rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_bit_tick && r_bit == 3'd7) w_next = RX_STOP;
            RX_STOP:  if (w_bit_tick) w_next = RX_IDLE;
            default:  w_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= RX_IDLE;
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_rx_prev <= w_rx;
            r_state   <= w_next;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            // Counter restarts on every state change and every data sample point
            if (r_state == RX_IDLE || w_next != r_state || w_bit_tick)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);
            if (r_state == RX_START)
                r_bit <= '0;
            if (r_state == RX_DATA && w_bit_tick) begin
                r_shift <= {w_rx, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
            if (r_state == RX_STOP && w_bit_tick) begin
                if (w_rx)
                    r_valid <= 1'b1;
                else
                    r_ferr  <= 1'b1;
            end
        end
    end

    assign data      = r_shift;
    assign valid     = r_valid;
    assign frame_err = r_ferr;

endmodule

// File: rtl/imem_loader.sv
// Loads instruction memory from a UART byte stream: 16-bit big-endian word count, then big-endian words.
module imem_loader
    import loader_defs::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    input  logic        load_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        frame_err,
    output logic [15:0] words_loaded
);

    session_state_t r_state, w_next;
    logic        r_load_d;
    logic [15:0] r_len, r_words;
    logic [23:0] r_word;
    logic [1:0]  r_pos;
    logic        r_we, r_ferr;
    logic [31:0] r_addr, r_wdata;
    logic        w_load_edge;
    logic [7:0]  w_byte;
    logic        w_byte_valid, w_byte_ferr;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .data      (w_byte),
        .valid     (w_byte_valid),
        .frame_err (w_byte_ferr)
    );

    assign w_load_edge = load_en & ~r_load_d;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_load_edge) w_next = S_LEN_HI;
            S_LEN_HI: if (w_byte_valid) w_next = S_LEN_LO;
            S_LEN_LO: if (w_byte_valid)
                          w_next = ({r_len[15:8], w_byte} == 16'd0) ? S_FINISH : S_DATA;
            S_DATA:   if (r_words == r_len) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_load_d <= 1'b0;
            r_len    <= '0;
            r_words  <= '0;
            r_word   <= '0;
            r_pos    <= '0;
            r_we     <= 1'b0;
            r_addr   <= BASE_ADDR;
            r_wdata  <= '0;
            r_ferr   <= 1'b0;
        end else begin
            r_load_d <= load_en;
            r_we     <= 1'b0;
            if (r_state == S_IDLE && w_load_edge) begin
                r_words <= '0;
                r_ferr  <= 1'b0;
            end else begin
                if (w_byte_ferr)
                    r_ferr <= 1'b1;
                if (r_we)
                    r_words <= r_words + 16'd1;
            end
            if (w_byte_valid) begin
                case (r_state)
                    S_LEN_HI: r_len[15:8] <= w_byte;
                    S_LEN_LO: begin
                        r_len[7:0] <= w_byte;
                        r_pos      <= '0;
                    end
                    S_DATA: begin
                        if (r_pos == 2'd3) begin
                            r_we    <= 1'b1;
                            r_wdata <= {r_word, w_byte};
                            // 32-bit sum wraps naturally past the top of the address space
                            r_addr  <= BASE_ADDR + {14'd0, r_words, 2'b00};
                            r_pos   <= '0;
                        end else begin
                            r_word <= {r_word[15:0], w_byte};
                            r_pos  <= r_pos + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we       = r_we;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign done         = (r_state == S_FINISH);
    assign cpu_hold     = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign frame_err    = r_ferr;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte-stream reference model.
module tb_imem_loader;

    localparam int unsigned CLKS = 16;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset, rx, load_en;
    logic        mem_we, cpu_hold, done, frame_err;
    logic [31:0] mem_addr, mem_wdata;
    logic [15:0] words_loaded;

    always #5 clock = ~clock;

    imem_loader #(.CLKS_PER_BIT(CLKS), .BASE_ADDR(BASE)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .load_en      (load_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .frame_err    (frame_err),
        .words_loaded (words_loaded)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] cap_q[$];
    logic [63:0] exp_q[$];
    int          done_cnt = 0;
    int          valid_cnt = 0;
    longint      cyc = 0;
    longint      done_cyc = 0;
    longint      valid_cyc = 0;
    logic        hold_at_done = 1'b1;
    logic        hold_after_arm = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (mem_we) cap_q.push_back({mem_addr, mem_wdata});
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            hold_at_done = cpu_hold;
        end
        if (dut.w_byte_valid) begin
            valid_cnt++;
            valid_cyc = cyc;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        repeat (CLKS) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLKS) @(negedge clock);
        end
        rx = stop_ok;
        repeat (CLKS) @(negedge clock);
        rx = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic clear_obs();
        cap_q.delete();
        done_cnt  = 0;
        valid_cnt = 0;
        hold_at_done = 1'b1;
    endtask

    task automatic arm();
        load_en = 1'b1;
        @(negedge clock);
        hold_after_arm = cpu_hold;
        load_en = 1'b0;
        @(negedge clock);
    endtask

    // Reference: word count from first two bytes, then one write per four following bytes
    function automatic void build_expected(input logic [7:0] bq[$]);
        int unsigned n;
        exp_q.delete();
        n = 32'({bq[0], bq[1]});
        for (int unsigned w = 0; w < n; w++) begin
            if (2 + 4 * w + 3 < 32'(bq.size()))
                exp_q.push_back({BASE + 32'(4 * w), bq[2+4*w], bq[3+4*w], bq[4+4*w], bq[5+4*w]});
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1; rx = 1'b1; load_en = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++; if ({mem_we, cpu_hold, done, frame_err} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got %b expected 0000", {mem_we, cpu_hold, done, frame_err}); end
        n_cmp++; if (mem_addr !== BASE) begin
            n_err++; $display("FAIL reset_addr: got %h expected %h", mem_addr, BASE); end
        n_cmp++; if (mem_wdata !== 32'h0) begin
            n_err++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
        n_cmp++; if (words_loaded !== 16'd0) begin
            n_err++; $display("FAIL reset_words: got %0d expected 0", words_loaded); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        logic [7:0] bq[$] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        clear_obs();
        arm();
        n_cmp++; if (hold_after_arm !== 1'b1) begin
            n_err++; $display("FAIL basic_hold_rise: got %b expected 1", hold_after_arm); end
        foreach (bq[i]) send_byte(bq[i], 1'b1);
        repeat (5) @(negedge clock);
        n_cmp++; if (cap_q.size() !== 2) begin
            n_err++; $display("FAIL basic_nwrites: got %0d expected 2", cap_q.size()); end
        n_cmp++; if (cap_q[0] !== 64'h00000000_20080005) begin
            n_err++; $display("FAIL basic_write0: got %h expected 0000000020080005", cap_q[0]); end
        n_cmp++; if (cap_q[1] !== 64'h00000004_00000000) begin
            n_err++; $display("FAIL basic_write1: got %h expected 0000000400000000", cap_q[1]); end
        n_cmp++; if (done_cnt !== 1) begin
            n_err++; $display("FAIL basic_done: got %0d expected 1", done_cnt); end
        n_cmp++; if (words_loaded !== 16'd2) begin
            n_err++; $display("FAIL basic_words: got %0d expected 2", words_loaded); end
        n_cmp++; if (hold_at_done !== 1'b0) begin
            n_err++; $display("FAIL basic_hold_at_done: got %b expected 0", hold_at_done); end
    endtask

    task automatic test_zero_len();
        clear_obs();
        arm();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (5) @(negedge clock);
        n_cmp++; if (cap_q.size() !== 0) begin
            n_err++; $display("FAIL zero_nwrites: got %0d expected 0", cap_q.size()); end
        n_cmp++; if (done_cnt !== 1) begin
            n_err++; $display("FAIL zero_done: got %0d expected 1", done_cnt); end
        n_cmp++; if (done_cyc - valid_cyc !== 64'sd1) begin
            n_err++; $display("FAIL zero_done_latency: got %0d expected 1", done_cyc - valid_cyc); end
        n_cmp++; if (cpu_hold !== 1'b0) begin
            n_err++; $display("FAIL zero_hold: got %b expected 0", cpu_hold); end
    endtask

    task automatic test_frame_err();
        clear_obs();
        arm();
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b0);
        n_cmp++; if (frame_err !== 1'b1) begin
            n_err++; $display("FAIL ferr_set: got %b expected 1", frame_err); end
        n_cmp++; if (valid_cnt !== 4) begin
            n_err++; $display("FAIL ferr_no_valid: got %0d expected 4", valid_cnt); end
        n_cmp++; if (cap_q.size() !== 0) begin
            n_err++; $display("FAIL ferr_early_write: got %0d expected 0", cap_q.size()); end
        send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
        repeat (15) @(negedge clock);
        n_cmp++; if (cap_q.size() !== 1 || cap_q[0] !== {BASE, 32'h1234ABCD}) begin
            n_err++; $display("FAIL ferr_write: got n=%0d %h expected n=1 %h", cap_q.size(), cap_q[0], {BASE, 32'h1234ABCD}); end
        n_cmp++; if (mem_wdata !== 32'h1234ABCD || mem_addr !== BASE) begin
            n_err++; $display("FAIL ferr_hold_outputs: got %h/%h expected %h/1234abcd", mem_addr, mem_wdata, BASE); end
        n_cmp++; if (frame_err !== 1'b1 || done_cnt !== 1) begin
            n_err++; $display("FAIL ferr_sticky_done: got ferr=%b done=%0d expected 1/1", frame_err, done_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        arm();
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({mem_we, cpu_hold, done, frame_err} !== 4'b0000) begin
            n_err++; $display("FAIL rstmid_flags: got %b expected 0000", {mem_we, cpu_hold, done, frame_err}); end
        n_cmp++; if (mem_addr !== BASE || mem_wdata !== 32'h0 || words_loaded !== 16'd0) begin
            n_err++; $display("FAIL rstmid_data: got %h/%h/%0d expected %h/0/0", mem_addr, mem_wdata, words_loaded, BASE); end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        clear_obs();
        arm();
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
        send_byte(8'hCA, 1'b1); send_byte(8'hFE, 1'b1);
        repeat (5) @(negedge clock);
        n_cmp++; if (cap_q.size() !== 1 || cap_q[0] !== {BASE, 32'hBEEFCAFE}) begin
            n_err++; $display("FAIL rstmid_new_session: got n=%0d %h expected n=1 %h", cap_q.size(), cap_q[0], {BASE, 32'hBEEFCAFE}); end
    endtask

    task automatic test_glitch_and_idle();
        clear_obs();
        rx = 1'b0;
        repeat (CLKS / 2) @(negedge clock);
        rx = 1'b1;
        repeat (3 * CLKS) @(negedge clock);
        n_cmp++; if (valid_cnt !== 0 || frame_err !== 1'b0) begin
            n_err++; $display("FAIL glitch: got valid=%0d ferr=%b expected 0/0", valid_cnt, frame_err); end
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        repeat (5) @(negedge clock);
        n_cmp++; if (cap_q.size() !== 0 || cpu_hold !== 1'b0 || done_cnt !== 0) begin
            n_err++; $display("FAIL idle_bytes: got writes=%0d hold=%b done=%0d expected 0/0/0", cap_q.size(), cpu_hold, done_cnt); end
    endtask

    task automatic test_second_load();
        logic [7:0] bq[$];
        bq = '{8'h00, 8'h02};
        for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
        build_expected(bq);
        clear_obs();
        arm();
        for (int i = 0; i < 4; i++) send_byte(bq[i], 1'b1);
        load_en = 1'b1;
        repeat (2) @(negedge clock);
        load_en = 1'b0;
        for (int i = 4; i < 10; i++) send_byte(bq[i], 1'b1);
        repeat (5) @(negedge clock);
        n_cmp++; if (cap_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL second_load_nwrites: got %0d expected %0d", cap_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_cmp++; if (cap_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL second_load_write%0d: got %h expected %h", i, cap_q[i], exp_q[i]); end
        end
        n_cmp++; if (done_cnt !== 1 || words_loaded !== 16'd2) begin
            n_err++; $display("FAIL second_load_end: got done=%0d words=%0d expected 1/2", done_cnt, words_loaded); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            logic [7:0] bq[$];
            int unsigned n;
            int          bad_idx;
            n = $urandom_range(1, 3);
            bq = '{8'h00, 8'(n)};
            for (int unsigned i = 0; i < 4 * n; i++) bq.push_back(8'($urandom));
            bad_idx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, bq.size() - 1)) : -1;
            build_expected(bq);
            clear_obs();
            arm();
            foreach (bq[i]) begin
                if (i == bad_idx) send_byte(8'($urandom), 1'b0);
                send_byte(bq[i], 1'b1);
            end
            repeat (5) @(negedge clock);
            n_cmp++; if (cap_q.size() !== exp_q.size()) begin
                n_err++; $display("FAIL rand%0d_nwrites: got %0d expected %0d", it, cap_q.size(), exp_q.size()); end
            foreach (exp_q[i]) begin
                n_cmp++; if (cap_q[i] !== exp_q[i]) begin
                    n_err++; $display("FAIL rand%0d_write%0d: got %h expected %h", it, i, cap_q[i], exp_q[i]); end
            end
            n_cmp++; if (done_cnt !== 1 || words_loaded !== 16'(n) || frame_err !== (bad_idx >= 0)) begin
                n_err++; $display("FAIL rand%0d_end: got done=%0d words=%0d ferr=%b expected 1/%0d/%b",
                                  it, done_cnt, words_loaded, frame_err, n, bad_idx >= 0); end
        end
    endtask

    task automatic test_max_len();
        logic [7:0] bq[$];
        bq = '{8'hFF, 8'hFF};
        for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
        build_expected(bq);
        clear_obs();
        arm();
        foreach (bq[i]) send_byte(bq[i], 1'b1);
        repeat (5) @(negedge clock);
        n_cmp++; if (words_loaded !== 16'd2 || cpu_hold !== 1'b1 || done_cnt !== 0) begin
            n_err++; $display("FAIL maxlen_state: got words=%0d hold=%b done=%0d expected 2/1/0", words_loaded, cpu_hold, done_cnt); end
        n_cmp++; if (cap_q.size() !== 2 || cap_q[1] !== exp_q[1]) begin
            n_err++; $display("FAIL maxlen_write1: got n=%0d %h expected n=2 %h", cap_q.size(), cap_q[1], exp_q[1]); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; rx = 1'b1; load_en = 1'b0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_zero_len();
        test_frame_err();
        test_reset_mid();
        test_glitch_and_idle();
        test_second_load();
        test_random();
        test_max_len();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
